// File: rtl/ledwalker_decoder.sv
// Receive-side checker for the walking-LED bus: locks onto the 14-step
// back-and-forth one-hot sequence and reports index, direction, sweeps and errors.
module ledwalker_decoder #(
    parameter int unsigned SWEEP_W = 16,
    parameter int unsigned ERR_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_led,
    output logic [3:0]         o_index,
    output logic               o_dir,
    output logic               o_locked,
    output logic               o_err,
    output logic [SWEEP_W-1:0] o_sweeps,
    output logic [ERR_W-1:0]   o_err_count
);

    localparam int unsigned LED_W   = 8;
    localparam int unsigned POS_W   = 3;
    localparam int unsigned IDX_W   = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(13);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [LED_W-1:0]   led_q, prev_q;
    logic [POS_W-1:0]   anchor_q, anchor_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               dir_q;
    logic               locked_q;
    logic               err_q, err_d;
    logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic               chg;
    logic               pos_ok;
    logic [POS_W-1:0]   pos;
    logic [IDX_W-1:0]   nxt_idx;

    // Expected LED word for a sequence index (rising half then falling half).
    function automatic logic [LED_W-1:0] idx_pat(input logic [IDX_W-1:0] idx);
        if (idx < IDX_W'(8)) begin
            return LED_W'(1) << idx[POS_W-1:0];
        end
        return LED_W'(1) << POS_W'(IDX_W'(14) - idx);
    endfunction

    assign chg = (led_q != prev_q);

    // One-hot position decode; zero or multi-hot words are invalid.
    always_comb begin
        pos    = '0;
        pos_ok = (led_q != '0) && ((led_q & (led_q - LED_W'(1))) == '0);
        for (int i = 0; i < int'(LED_W); i++) begin
            if (led_q[i]) begin
                pos = POS_W'(i);
            end
        end
    end

    assign nxt_idx = (index_q == LAST_IDX) ? '0 : index_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        anchor_d  = anchor_q;
        index_d   = index_q;
        err_d     = 1'b0;
        sweeps_d  = sweeps_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            HUNT: begin
                if (pos_ok) begin
                    anchor_d = pos;
                    state_d  = ALIGN;
                end
            end
            ALIGN: begin
                if (chg) begin
                    if (pos_ok && ({1'b0, pos} == ({1'b0, anchor_q} + IDX_W'(1)))) begin
                        index_d = {1'b0, pos};
                        state_d = LOCKED;
                    end else if (pos_ok && (anchor_q != '0) && (pos == anchor_q - POS_W'(1))) begin
                        // Falling step: bit 0 maps to index 0, other bits to the descending half.
                        index_d = (pos == '0) ? '0 : IDX_W'(14) - {1'b0, pos};
                        state_d = LOCKED;
                    end else begin
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (chg) begin
                    if (led_q == idx_pat(nxt_idx)) begin
                        index_d = nxt_idx;
                        if (index_q == LAST_IDX) begin
                            sweeps_d = sweeps_q + SWEEP_W'(1);
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            led_q     <= '0;
            prev_q    <= '0;
            state_q   <= HUNT;
            anchor_q  <= '0;
            index_q   <= '0;
            dir_q     <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            sweeps_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            led_q     <= i_led;
            prev_q    <= led_q;
            state_q   <= state_d;
            anchor_q  <= anchor_d;
            index_q   <= index_d;
            dir_q     <= (index_d >= IDX_W'(7));
            locked_q  <= (state_d == LOCKED);
            err_q     <= err_d;
            sweeps_q  <= sweeps_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_index     = index_q;
    assign o_dir       = dir_q;
    assign o_locked    = locked_q;
    assign o_err       = err_q;
    assign o_sweeps    = sweeps_q;
    assign o_err_count = err_cnt_q;

endmodule
